telemetry_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one byte-wide UART transmitter between `NUM_CH` telemetry requesters (attitude, motor, battery and similar). Each requester offers a 16-bit value. The block latches the winner's value, frames it as a multi-byte packet and drives the transmitter's start/data/busy handshake one byte at a time. It sits between the flight-control datapath and the serial telemetry link.

---
 rtl/telemetry_tx_scheduler.sv | 151 +++++++++++++++
 tb/tb_telemetry_tx_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_tx_scheduler.sv
// Round-robin scheduler framing one 16-bit telemetry value per grant onto a byte-wide UART transmitter.
// Latency: ack one cycle after req is seen in IDLE, first tx_start one cycle after ack when the transmitter is idle.
// Backpressure: each byte waits in SEND/WAIT while tx_busy is high; requesters are held off until the frame ends.
// Optional checksum byte enabled by defining TELEMETRY_SCHED_CHECKSUM_EN.
module telemetry_tx_scheduler #(
    parameter int         NUM_CH = 4,
    parameter logic [7:0] HEADER = 8'hAA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req,
    input  logic [16*NUM_CH-1:0] data,
    output logic [NUM_CH-1:0]    ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef TELEMETRY_SCHED_CHECKSUM_EN
    localparam logic [2:0] LastByte = 3'd4;
`else
    localparam logic [2:0] LastByte = 3'd3;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StGuard,
        StWait,
        StDone
    } state_t;

    // Value captured at grant time; later data changes do not reach the frame.
    typedef struct packed {
        logic [ChW-1:0] chan;
        logic [15:0]    value;
    } frame_t;

    state_t         state;
    frame_t         frame;
    logic [2:0]     idx;
    logic [ChW-1:0] last;

    logic [ChW-1:0] winIdx;
    logic [15:0]    winData;
    logic           anyReq;
    logic [7:0]     chanByte;
    logic [7:0]     curByte;

`ifdef TELEMETRY_SCHED_CHECKSUM_EN
    logic [7:0]     checkSum;
`endif

    assign anyReq   = |req;
    assign winData  = data[16*int'(winIdx) +: 16];
    assign chanByte = {{(8-ChW){1'b0}}, frame.chan};

`ifdef TELEMETRY_SCHED_CHECKSUM_EN
    // Wrap-around byte sum of index and payload; the header is not covered.
    assign checkSum = chanByte + frame.value[15:8] + frame.value[7:0];
`endif

    // Round-robin search starting after the last grant; nearest requester wins.
    always_comb begin
        winIdx = last;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_CH]) begin
                winIdx = ChW'((int'(last) + k) % NUM_CH);
            end
        end
    end

    // Select the frame byte addressed by the byte index.
    always_comb begin
        curByte = 8'h00;
        case (idx)
            3'd0:    curByte = HEADER;
            3'd1:    curByte = chanByte;
            3'd2:    curByte = frame.value[15:8];
            3'd3:    curByte = frame.value[7:0];
`ifdef TELEMETRY_SCHED_CHECKSUM_EN
            3'd4:    curByte = checkSum;
`endif
            default: curByte = 8'h00;
        endcase
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            frame      <= '0;
            idx        <= 3'd0;
            last       <= ChW'(NUM_CH - 1);
            ack        <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ack        <= '0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (anyReq) begin
                        frame.chan   <= winIdx;
                        frame.value  <= winData;
                        ack[winIdx]  <= 1'b1;
                        last         <= winIdx;
                        idx          <= 3'd0;
                        busy         <= 1'b1;
                        state        <= StSend;
                    end
                end
                StSend: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= curByte;
                        state    <= StGuard;
                    end
                end
                StGuard: begin
                    // Transmitter busy lags start by a cycle, so it is not trusted here.
                    state <= StWait;
                end
                StWait: begin
                    if (!tx_busy) begin
                        if (idx == LastByte) begin
                            frame_done <= 1'b1;
                            state      <= StDone;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= StSend;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// Self-checking bench for telemetry_tx_scheduler with a busy-flag transmitter model.
// Expected bytes and grants are queued at stimulus time and checked as the DUT emits them.
// Transmitter busy time is programmable per test to exercise the handshake.
`timescale 1ns/1ps
module tb_telemetry_tx_scheduler;

    localparam int NCH = 4;
`ifdef TELEMETRY_SCHED_CHECKSUM_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [16*NCH-1:0] data = '0;
    logic [NCH-1:0]    ack;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              busy;
    logic              frame_done;

    telemetry_tx_scheduler #(.NUM_CH(NCH), .HEADER(8'hAA)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCH-1:0] reqM;
        logic [15:0]    chData;
        logic [NCH-1:0] expAck;
    } vec_t;

    vec_t           vecs[8];
    logic [7:0]     expByteQ[$];
    logic [NCH-1:0] expAckQ[$];

    int nVec = 0;
    int nErr = 0;
    int ackSeen = 0;
    int doneSeen = 0;
    int bytesInFrame = 0;
    int busyLen = 4;
    int busyCnt = 0;
    int ackCyc = 0;
    int doneCyc = 0;
    bit chkLat = 1'b0;
    bit chkGap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nVec++;
        nErr++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic pushFrame(input int ch, input logic [15:0] v);
        logic [7:0] c;
        logic [7:0] s;
        c = 8'(ch);
        s = c + v[15:8] + v[7:0];
        expByteQ.push_back(8'hAA);
        expByteQ.push_back(c);
        expByteQ.push_back(v[15:8]);
        expByteQ.push_back(v[7:0]);
        if (FL == 5) expByteQ.push_back(s);
        expAckQ.push_back(NCH'(1) << ch);
    endtask

    task automatic waitAck(input int target, input int bound);
        for (int i = 0; i < bound && ackSeen < target; i++) @(negedge clk);
        if (ackSeen < target) timeoutFail("wait_ack");
    endtask

    task automatic waitDone(input int target, input int bound);
        for (int i = 0; i < bound && doneSeen < target; i++) @(negedge clk);
        if (doneSeen < target) timeoutFail("wait_frame_done");
    endtask

    // Output monitor plus transmitter model: busy rises the half-cycle after a start is seen.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (ack != '0) begin
                if (expAckQ.size() == 0) begin
                    nVec++; nErr++;
                    $display("FAIL ack_unexpected: got %0h, required none", ack);
                end else begin
                    check("ack_grant", ack, expAckQ.pop_front());
                end
                if (chkGap) check("ack_after_done_gap", cyc - doneCyc, 2);
                check("busy_at_ack", busy, 1);
                ackSeen++;
                ackCyc = cyc;
                bytesInFrame = 0;
            end
            if (tx_start) begin
                check("start_while_tx_busy", tx_busy, 0);
                if (chkLat && bytesInFrame == 0) check("first_start_latency", cyc - ackCyc, 1);
                if (expByteQ.size() == 0) begin
                    nVec++; nErr++;
                    $display("FAIL byte_unexpected: got %0h, required none", tx_data);
                end else begin
                    check("tx_byte", tx_data, expByteQ.pop_front());
                end
                bytesInFrame++;
            end
            if (frame_done) begin
                check("bytes_per_frame", bytesInFrame, FL);
                check("busy_at_done", busy, 1);
                doneSeen++;
                doneCyc = cyc;
            end
        end
        if (tx_start) busyCnt = busyLen;
        else if (busyCnt > 0) busyCnt--;
        tx_busy = (busyCnt > 0);
    end

    initial begin
        vecs[0] = '{4'b0100, 16'h1234, 4'b0100};
        vecs[1] = '{4'b0001, 16'h0000, 4'b0001};
        vecs[2] = '{4'b1000, 16'hFFFF, 4'b1000};
        vecs[3] = '{4'b0010, 16'h8001, 4'b0010};
        vecs[4] = '{4'b0101, 16'h00FF, 4'b0100};
        vecs[5] = '{4'b1111, 16'hA5C3, 4'b1000};
        vecs[6] = '{4'b0011, 16'h5A5A, 4'b0001};
        vecs[7] = '{4'b1010, 16'h7E81, 4'b0010};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Table-driven single-request frames, each starting from an idle transmitter
        chkLat = 1'b1;
        for (int v = 0; v < 8; v++) begin
            int w;
            w = 0;
            for (int b = 0; b < NCH; b++) if (vecs[v].expAck[b]) w = b;
            busyLen = $urandom_range(1, 6);
            for (int b = 0; b < NCH; b++) data[16*b +: 16] = (b == w) ? vecs[v].chData : ~vecs[v].chData;
            pushFrame(w, vecs[v].chData);
            req = vecs[v].reqM;
            waitAck(ackSeen + 1, 50);
            req = '0;
            waitDone(doneSeen + 1, 200);
            @(negedge clk);
            check("busy_after_frame", busy, 0);
            check("queue_drained", expByteQ.size(), 0);
        end

        // Fairness with all requests held and a slow transmitter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busyLen = 87;
        for (int b = 0; b < NCH; b++) data[16*b +: 16] = 16'h1000 * (b + 1) + 16'(b);
        for (int f = 0; f < 5; f++) pushFrame(f % NCH, 16'h1000 * ((f % NCH) + 1) + 16'(f % NCH));
        begin
            int a0;
            int d0;
            a0 = ackSeen;
            d0 = doneSeen;
            req = 4'b1111;
            waitAck(a0 + 1, 50);
            chkGap = 1'b1;
            waitAck(a0 + 5, 3000);
            req = '0;
            waitDone(d0 + 5, 3000);
            chkGap = 1'b0;
        end
        check("fair_queue_drained", expByteQ.size(), 0);

        // Reset during the third byte's WAIT; next frame must wait out the in-flight byte
        busyLen = 20;
        data[16*1 +: 16] = 16'hBEEF;
        pushFrame(1, 16'hBEEF);
        req = 4'b0010;
        waitAck(ackSeen + 1, 50);
        req = '0;
        for (int i = 0; i < 300 && bytesInFrame < 3; i++) @(negedge clk);
        if (bytesInFrame < 3) timeoutFail("wait_third_byte");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ack", ack, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        @(negedge clk);
        expByteQ.delete();
        expAckQ.delete();
        chkLat = 1'b0;
        data[16*0 +: 16] = 16'h0F0F;
        pushFrame(0, 16'h0F0F);
        req = 4'b0001;
        rst = 1'b0;
        waitAck(ackSeen + 1, 50);
        req = '0;
        waitDone(doneSeen + 1, 400);
        check("rst_queue_drained", expByteQ.size(), 0);
        chkLat = 1'b1;

        // Data changes one cycle after ack must not reach the frame
        busyLen = 5;
        data[16*1 +: 16] = 16'hABCD;
        pushFrame(1, 16'hABCD);
        req = 4'b0010;
        waitAck(ackSeen + 1, 50);
        @(negedge clk);
        data[16*1 +: 16] = 16'h0000;
        req = '0;
        waitDone(doneSeen + 1, 200);
        check("late_queue_drained", expByteQ.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
